// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Owns the PC, issues word reads to a
//            one-cycle-latency instruction memory, buffers {pc, instruction}
//            pairs in a small FIFO and hands them to decode via valid/ready.
//            A redirect flushes buffered and in-flight fetches.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_redirect,
  input  logic [DATA_WIDTH-1:0] i_redirect_pc,
  output logic                  o_imem_req,
  output logic [DATA_WIDTH-1:0] o_imem_addr,
  input  logic [DATA_WIDTH-1:0] i_imem_rdata,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_instruction,
  output logic [DATA_WIDTH-1:0] o_pc,
  input  logic                  i_ready
);

  localparam int c_pw = $clog2(FIFO_DEPTH);
  localparam int c_cw = c_pw + 1;
  localparam logic [c_cw:0] c_depth = (c_cw+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_run;

  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [DATA_WIDTH-1:0] r_req_addr;
  logic                  r_inflight;

  logic [DATA_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [c_pw-1:0]       r_rd_ptr;
  logic [c_pw-1:0]       r_wr_ptr;
  logic [c_cw-1:0]       r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_req;
  logic [c_cw:0]         w_credit;

  // State register: leaves IDLE on the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and request decision; in-flight slots count against FIFO space.
  always_comb begin
    w_state_nxt = S_RUN;
    w_run       = (r_state == S_RUN);
    w_pop       = o_valid & i_ready;
    w_push      = r_inflight & ~i_redirect;
    w_credit    = {1'b0, r_count} + {{c_cw{1'b0}}, r_inflight} - {{c_cw{1'b0}}, w_pop};
    w_req       = w_run & ~i_redirect & (w_credit < c_depth);
  end

  assign o_imem_req    = w_req;
  assign o_imem_addr   = r_fetch_pc;
  assign o_valid       = (r_count != '0);
  assign o_pc          = r_fifo_pc[r_rd_ptr];
  assign o_instruction = r_fifo_instr[r_rd_ptr];

  // PC advance, redirect reload and capture of the address awaiting a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (i_redirect) begin
        r_fetch_pc <= {i_redirect_pc[DATA_WIDTH-1:2], 2'b00};
      end else if (w_req) begin
        r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
        r_req_addr <= r_fetch_pc;
      end
    end
  end

  // FIFO storage and pointers; a redirect empties it and drops the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wr_ptr]    <= r_req_addr;
        r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
        r_wr_ptr               <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + c_cw'(w_push) - c_cw'(w_pop);
    end
  end

endmodule
`default_nettype wire
